// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative ALU: op codes, flag bit positions
// and the control FSM state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply (low W bits) and restoring
// unsigned divide/remainder. done/result present the final step combinationally.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic         is_rem,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         div0
);

  localparam int CW = $clog2(W) + 1;

  // acc: product accumulator / partial remainder; opa: multiplicand / quotient
  // shift register; opb: multiplier / divisor.
  logic [CW-1:0] count;
  logic [W-1:0]  acc;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          div_mode;
  logic          rem_mode;
  logic          dz;

  logic [W-1:0]  acc_nx;
  logic [W-1:0]  opa_nx;
  logic [W-1:0]  opb_nx;
  logic [W:0]    rs;
  logic [W-1:0]  diff;
  logic          ge;

  // Next value of the datapath for one iteration of the selected algorithm.
  // With a zero divisor every step subtracts nothing, so the quotient fills with
  // ones and the remainder rebuilds the dividend, matching the required results.
  always_comb begin
    rs     = {acc, opa[W-1]};
    diff   = rs[W-1:0] - opb;
    ge     = (rs >= {1'b0, opb});
    acc_nx = acc;
    opa_nx = opa;
    opb_nx = opb;
    if (div_mode) begin
      acc_nx = ge ? diff : rs[W-1:0];
      opa_nx = {opa[W-2:0], ge};
      opb_nx = opb;
    end else begin
      acc_nx = opb[0] ? (acc + opa) : acc;
      opa_nx = {opa[W-2:0], 1'b0};
      opb_nx = {1'b0, opb[W-1:1]};
    end
  end

  assign busy   = (count != {CW{1'b0}});
  assign done   = busy && (count == CW'(1));
  assign result = (div_mode && !rem_mode) ? opa_nx : acc_nx;
  assign div0   = div_mode && dz;

  // Operand load on start, then one iteration per cycle until the counter empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= {CW{1'b0}};
      acc      <= {W{1'b0}};
      opa      <= {W{1'b0}};
      opb      <= {W{1'b0}};
      div_mode <= 1'b0;
      rem_mode <= 1'b0;
      dz       <= 1'b0;
    end else if (start) begin
      count    <= CW'(W);
      acc      <= {W{1'b0}};
      opa      <= a;
      opb      <= b;
      div_mode <= is_div || is_rem;
      rem_mode <= is_rem;
      dz       <= (b == {W{1'b0}});
    end else if (busy) begin
      count    <= count - CW'(1);
      acc      <= acc_nx;
      opa      <= opa_nx;
      opb      <= opb_nx;
    end else begin
      count    <= count;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Sequential W-bit ALU with valid/ready on both sides; single-cycle ops are
// computed here, multiply/divide/remainder are delegated to alu_muldiv_iter.
module alu_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  localparam int SHW = $clog2(W);

  state_t         state;
  logic           ready_ok;
  logic           accept;
  logic           md_start;
  logic           md_busy;
  logic           md_done;
  logic           md_div0;
  logic [W-1:0]   md_result;
  logic [3:0]     md_flags;

  logic [W-1:0]   sc_res;
  logic [3:0]     sc_flags;
  logic           sc_c;
  logic           sc_v;
  logic [W:0]     sum;
  logic [SHW-1:0] shamt;

  // ready_ok keeps in_ready low throughout reset and until the first clock after release.
  assign in_ready = ready_ok && !md_busy && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_muldiv(op);
  assign shamt    = b[SHW-1:0];

  alu_muldiv_iter #(.W(W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (op == OP_DIVU),
    .is_rem (op == OP_REMU),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result),
    .div0   (md_div0)
  );

  // Single-cycle result and flags from the live operands; reserved codes yield zero.
  always_comb begin
    sc_res = {W{1'b0}};
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sum    = {(W+1){1'b0}};
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        sc_res = sum[W-1:0];
        sc_c   = sum[W];
        sc_v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        sc_res = sum[W-1:0];
        sc_c   = sum[W];
        sc_v   = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLT:  sc_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(W-1){1'b0}}, (a < b)};
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      default: sc_res = {W{1'b0}};
    endcase
    sc_flags         = 4'b0000;
    sc_flags[FLAG_N] = sc_res[W-1];
    sc_flags[FLAG_Z] = (sc_res == {W{1'b0}});
    sc_flags[FLAG_C] = sc_c;
    sc_flags[FLAG_V] = sc_v;
  end

  // Flags for the iterative ops: carry never set, overflow marks a zero divisor.
  always_comb begin
    md_flags         = 4'b0000;
    md_flags[FLAG_N] = md_result[W-1];
    md_flags[FLAG_Z] = (md_result == {W{1'b0}});
    md_flags[FLAG_C] = 1'b0;
    md_flags[FLAG_V] = md_div0;
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_ok  <= 1'b0;
      out_valid <= 1'b0;
      res       <= {W{1'b0}};
      flags     <= 4'b0000;
    end else begin
      ready_ok <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_muldiv(op)) begin
              state     <= BUSY;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              res       <= sc_res;
              flags     <= sc_flags;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end else begin
            state <= state;
          end
        end
        BUSY: begin
          if (md_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            res       <= md_result;
            flags     <= md_flags;
          end else begin
            state <= BUSY;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter at W=32, plus a W=8 instance for the
// narrow-width ADD overflow case.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [3:0]  op = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic [3:0]  flags;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = 8'd0;
  logic [7:0]  b8 = 8'd0;
  logic [3:0]  op8 = 4'd0;
  logic        out_valid8;
  logic [7:0]  res8;
  logic [3:0]  flags8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_iter #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flags(flags)
  );

  alu_iter #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(1'b1),
    .res(res8), .flags(flags8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Present one op, let it be taken on the next edge, return #1 after that edge.
  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from acceptance until out_valid, and whether in_ready rose meanwhile.
  task automatic wait_out(output int lat, output int rdy_seen);
    lat = 1; rdy_seen = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One complete op with result, flags and latency checked.
  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] er, input logic [3:0] ef,
                     input int elat);
    int lat, rdy;
    send(o, x, y);
    wait_out(lat, rdy);
    check({tag, "_res"}, res, er);
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
    check({tag, "_lat"}, lat, elat);
    if (elat > 1) check({tag, "_busy_rdy"}, rdy, 32'd0);
  endtask

  initial begin
    int hits;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    run("add_ovf",  4'd0,  32'h7FFF_FFF5, 32'd11,        32'h8000_0000, 4'b1001, 1);
    run("add_zero", 4'd0,  32'd11,        32'hFFFF_FFF5, 32'h0000_0000, 4'b0110, 1);
    run("sub_neg",  4'd1,  32'd20,        32'd25,        32'hFFFF_FFFB, 4'b1000, 1);
    run("sra",      4'd9,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 4'b1000, 1);
    run("slt",      4'd5,  32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0000, 1);
    run("sltu",     4'd6,  32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0100, 1);
    run("xor",      4'd4,  32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F, 4'b0000, 1);
    run("rsvd",     4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         4'b0100, 1);
    run("mul",      4'd10, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 4'b0000, 33);
    run("divu",     4'd11, 32'd100,       32'd7,         32'd14,        4'b0000, 33);
    run("remu",     4'd12, 32'd100,       32'd7,         32'd2,         4'b0000, 33);
    run("divu0",    4'd11, 32'd5,         32'd0,         32'hFFFF_FFFF, 4'b1001, 33);
    run("remu0",    4'd12, 32'd5,         32'd0,         32'd5,         4'b0001, 33);

    // Backpressure: hold the result, then accept a queued AND as it is consumed.
    @(posedge clk); #1;
    out_ready = 1'b0;
    run("bp_add", 4'd0, 32'd1, 32'd2, 32'd3, 4'b0000, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", res, 32'd3);
      check("bp_hold_flags", {28'd0, flags}, 32'd0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    op = 4'd2; a = 32'hF0F0_1234; b = 32'hFF00_00FF; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("bp_same_cycle_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_and_valid", {31'd0, out_valid}, 32'd1);
    check("bp_and_res", res, 32'hF000_0034);
    @(posedge clk); #1;
    check("bp_back_idle", {31'd0, out_valid}, 32'd0);

    // Reset during the tenth busy cycle of a multiply.
    send(4'd10, 32'h0001_0003, 32'h0002_0005);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("postrst_res", res, 32'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) hits++;
      @(posedge clk); #1;
    end
    check("postrst_no_stale", hits, 32'd0);
    run("postrst_add", 4'd0, 32'd40, 32'd2, 32'd42, 4'b0000, 1);

    // Narrow instance: 0x7F + 1 overflows into the sign bit.
    op8 = 4'd0; a8 = 8'h7F; b8 = 8'h01; in_valid8 = 1'b1;
    #1 check("w8_in_ready", {31'd0, in_ready8}, 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8_valid", {31'd0, out_valid8}, 32'd1);
    check("w8_res", {24'd0, res8}, 32'h0000_0080);
    check("w8_flags", {28'd0, flags8}, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
